muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 46 ++++
 rtl/muldiv_step.sv | 46 ++++
 rtl/muldiv_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the default datapath and iteration widths, the funct3 operation
// encoding, the FSM state encoding and small operation-decode helpers.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Divide/remainder family
  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Remainder returns the partial remainder rather than the quotient
  function automatic logic op_is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // rs1 treated as two's complement
  function automatic logic op_sign_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 treated as two's complement
  function automatic logic op_sign_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential multiply/divide datapath.
// The 2*XLEN accumulator is split into {i_hi, i_lo}.
//   multiply: radix-2 shift-add, i_lo holds the remaining multiplier bits,
//             i_opnd is the multiplicand; the accumulator shifts right.
//   divide:   restoring shift-subtract, i_hi is the partial remainder,
//             i_lo the dividend/quotient, i_opnd the divisor.
// Ports:
//   i_is_div      select divide step (1) or multiply step (0)
//   i_hi, i_lo    current accumulator halves
//   i_opnd        multiplicand or divisor magnitude
//   o_hi, o_lo    next accumulator halves
//   o_qbit        quotient bit produced by this divide step
import muldiv_pkg::*;

module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_qbit
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_hi, i_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_opnd};
    // Borrow out of the trial subtraction means the divisor did not fit
    o_qbit  = ~w_diff[XLEN];
    if (i_is_div) begin
      o_hi = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], o_qbit};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit for the Execute stage.
// Iterates on operand magnitudes for ITER cycles (ITER must equal XLEN for
// the radix-2 datapath) and applies sign correction on entry to DONE.
// Divide-by-zero and signed overflow take a one-cycle fast path.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   StartE        M-extension op valid in Execute
//   funct3E       operation select
//   SrcAE, SrcBE  rs1 / rs2 operands
//   FlushE        squash of the Execute instruction
//   StallMD       combinational stall request for Fetch/Decode/Execute
//   DoneE         result valid this cycle
//   ResultE       registered result
//   BusyE         unit is not idle
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN,
  parameter int unsigned ITER = muldiv_pkg::ITER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic            BusyE
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  op_e               r_op,     w_op_nxt;
  logic              r_neg_q,  w_neg_q_nxt;
  logic              r_neg_r,  w_neg_r_nxt;
  logic [XLEN-1:0]   r_hi,     w_hi_nxt;
  logic [XLEN-1:0]   r_lo,     w_lo_nxt;
  logic [XLEN-1:0]   r_opnd,   w_opnd_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_busy;
  logic              w_stall_c;

  // Decode of the incoming instruction
  op_e             w_op_in;
  logic            w_div_in;
  logic            w_rem_in;
  logic            w_sa_in;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  always_comb begin
    w_op_in  = op_e'(funct3E);
    w_div_in = op_is_div(w_op_in);
    w_rem_in = op_is_rem(w_op_in);
    w_sa_in  = op_sign_a(w_op_in);
    w_neg_a  = w_sa_in & SrcAE[XLEN-1];
    w_neg_b  = op_sign_b(w_op_in) & SrcBE[XLEN-1];
    w_abs_a  = w_neg_a ? (~SrcAE + XLEN'(1)) : SrcAE;
    w_abs_b  = w_neg_b ? (~SrcBE + XLEN'(1)) : SrcBE;
  end

  // Single iteration of the shared datapath
  logic [XLEN-1:0] w_step_hi;
  logic [XLEN-1:0] w_step_lo;
  logic            w_step_qbit;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (op_is_div(r_op)),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opnd   (r_opnd),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo),
    .o_qbit   (w_step_qbit)
  );

  // Sign-corrected results computed from the final iteration's outputs
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_prod_c;
  logic [XLEN-1:0] w_quo_c;
  logic [XLEN-1:0] w_rem_c;

  always_comb begin
    w_prod   = {w_step_hi, w_step_lo};
    w_prod_c = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
    w_quo_c  = r_neg_q ? (~w_step_lo + XLEN'(1)) : w_step_lo;
    w_rem_c  = r_neg_r ? (~w_step_hi + XLEN'(1)) : w_step_hi;
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_opnd_nxt   = r_opnd;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;
    w_stall_c    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_stall_c = StartE & ~FlushE;
        if (StartE && !FlushE) begin
          w_op_nxt    = w_op_in;
          w_cnt_nxt   = '0;
          w_hi_nxt    = '0;
          w_lo_nxt    = w_abs_a;
          w_opnd_nxt  = w_abs_b;
          w_neg_q_nxt = w_neg_a ^ w_neg_b;
          w_neg_r_nxt = w_neg_a;
          if (w_div_in && (SrcBE == '0)) begin
            w_state_nxt  = S_DONE;
            w_done_nxt   = 1'b1;
            w_result_nxt = w_rem_in ? SrcAE : '1;
          end else if (w_div_in && w_sa_in && (SrcAE == MIN_NEG) && (SrcBE == '1)) begin
            w_state_nxt  = S_DONE;
            w_done_nxt   = 1'b1;
            w_result_nxt = w_rem_in ? '0 : MIN_NEG;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        w_stall_c = 1'b1;
        if (FlushE) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hi_nxt  = w_step_hi;
          w_lo_nxt  = w_step_lo;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ITER - 1)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            unique case (r_op)
              OP_MUL:                        w_result_nxt = w_prod_c[XLEN-1:0];
              OP_MULH, OP_MULHSU, OP_MULHU:  w_result_nxt = w_prod_c[PW-1:XLEN];
              OP_DIV, OP_DIVU:               w_result_nxt = w_quo_c;
              OP_REM, OP_REMU:               w_result_nxt = w_rem_c;
              default:                       w_result_nxt = r_result;
            endcase
          end
        end
      end

      // Same instruction is still in Execute: StartE and FlushE are ignored
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (reset) begin
      w_stall_c = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_opnd   <= w_opnd_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign StallMD = w_stall_c;
  assign DoneE   = r_done;
  assign ResultE = r_result;
  assign BusyE   = r_busy;

endmodule
